// File: rtl/hc_dwell_logger.sv
// Dwell logger: measures how long the comparator decision stays at each level and
// queues {level, length, saturated} records in a FWFT FIFO. Optional glitch filter: HC_DWELL_FILTER_EN.
module hc_dwell_logger #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_DWELL  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          cmp_in,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic                          evt_level,
  output logic [CNT_W-1:0]              evt_len,
  output logic                          evt_sat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          drop,
  input  logic                          clr_drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

  typedef struct packed {
    logic             level;
    logic [CNT_W-1:0] len;
    logic             sat;
  } rec_t;

  state_t           r_state;
  logic             r_lvl_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_acc;
  logic             w_edge;
  logic             w_push;
  rec_t             w_rec;

`ifdef HC_DWELL_FILTER_EN
  localparam int FW = $clog2(MIN_DWELL + 1);
  logic [FW-1:0] r_flt_cnt;
  logic          w_diff;

  // A differing input is accepted on its MIN_DWELL-th consecutive cycle.
  assign w_diff = (cmp_in != r_lvl_q);
  assign w_acc  = (w_diff && (r_flt_cnt == FW'(MIN_DWELL - 1))) ? cmp_in : r_lvl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flt_cnt <= '0;
    end else if (!enable || (r_state == S_IDLE) || !w_diff || (w_acc != r_lvl_q)) begin
      r_flt_cnt <= '0;
    end else begin
      r_flt_cnt <= r_flt_cnt + 1'b1;
    end
  end
`else
  assign w_acc = cmp_in;
`endif

  assign w_edge = (r_state != S_IDLE) && (w_acc != r_lvl_q);
  assign w_push = enable && (r_state == S_RUN) && w_edge;
  assign w_rec  = '{level: r_lvl_q, len: r_cnt, sat: (r_cnt == CNT_MAX)};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_lvl_q <= 1'b0;
      r_cnt   <= '0;
    end else if (!enable) begin
      r_state <= S_IDLE;
      r_lvl_q <= cmp_in;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_lvl_q <= cmp_in;
          r_cnt   <= '0;
          r_state <= S_ARMED;
        end
        S_ARMED: begin
          r_lvl_q <= w_acc;
          if (w_edge) begin
            r_cnt   <= CNT_W'(1);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_lvl_q <= w_acc;
          if (w_edge)               r_cnt <= CNT_W'(1);
          else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  rec_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  rec_t          w_head;

  assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = evt_valid && evt_ready;
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_head = r_mem[r_rd_ptr];

  // NOTE: storage is not reset; the count alone defines validity and outputs
  // are masked while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_rec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      drop     <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) drop <= 1'b1;
      else if (clr_drop)              drop <= 1'b0;
    end
  end

  assign evt_valid = (r_count != '0);
  assign evt_level = evt_valid & w_head.level;
  assign evt_len   = evt_valid ? w_head.len : '0;
  assign evt_sat   = evt_valid & w_head.sat;
  assign fifo_cnt  = r_count;

endmodule
